// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtraction controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: Difference = A - B - Bin, Bout = borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Difference,
    output logic Bout
);

    assign Difference = A ^ B ^ Bin;
    assign Bout       = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial sequencer computing (a - b - bin) mod 2^WIDTH, LSB first,
// one full_subtractor step per clock with a registered borrow between bits.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] d_sh_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             diff_bit_s;
    logic             bout_bit_s;
    logic [WIDTH-1:0] d_cat_s;

    full_subtractor u_cell (
        .A          (a_sh_q[0]),
        .B          (b_sh_q[0]),
        .Bin        (borrow_q),
        .Difference (diff_bit_s),
        .Bout       (bout_bit_s)
    );

    // The result register only needs WIDTH-1 stored bits: the last bit comes
    // straight from the cell on the final edge.
    assign d_cat_s = {diff_bit_s, d_sh_q};

    // Controller state, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            d_sh_q   <= {(WIDTH-1){1'b0}};
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= SHIFT;
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= bin;
                        cnt_q    <= {CNT_W{1'b0}};
                        d_sh_q   <= {(WIDTH-1){1'b0}};
                        busy_q   <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    d_sh_q   <= d_cat_s[WIDTH-1:1];
                    borrow_q <= bout_bit_s;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        diff_q  <= d_cat_s;
                        bout_q  <= bout_bit_s;
                        done_q  <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= {CNT_W{1'b0}};
                    borrow_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 handshake/latency vectors and a
// WIDTH=2 exhaustive sweep against an arithmetic reference.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, bin;
    logic [7:0] a, b;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       start2, bin2;
    logic [1:0] a2, b2;
    logic       busy2, done2, bout2;
    logic [1:0] diff2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_sub_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Starts at a negedge; returns at the negedge after done has been seen.
    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic bi, input logic [7:0] ed, input logic eb);
        int lat;
        int busy_low;
        start = 1'b1; a = av; b = bv; bin = bi;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_low = 0;
        if (!busy) busy_low++;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!busy) busy_low++;
        end
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_busy_on"}, busy_low, 0);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, bout, eb);
        @(negedge clk);
        chk({tag, "_busy_off"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        int gap;
        logic [2:0] mdl;

        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h01; bin = 1'b1;
        start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; bin2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        do_op("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        do_op("under", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        do_op("bin0",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        do_op("ffff",  8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

        // Late start during SHIFT must be ignored.
        start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk); start = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("ign_lat", lat, 9);
        chk("ign_diff", diff, 8'h0F);
        chk("ign_bout", bout, 1'b0);
        @(negedge clk);
        chk("ign_idle", busy, 1'b0);

        // start held high: back-to-back operations, WIDTH+2 cycles apart.
        start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
        @(posedge clk);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 20);
        chk("hold1_lat", lat, 9);
        chk("hold1_diff", diff, 8'h02);
        a = 8'h20; b = 8'h01;
        gap = 0;
        do begin
            @(negedge clk); gap++;
            if (gap == 5) chk("hold_stable", diff, 8'h02);
        end while (!done && gap < 20);
        chk("hold_gap", gap, 10);
        chk("hold2_diff", diff, 8'h1F);
        chk("hold2_bout", bout, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_idle", busy, 1'b0);

        // Reset during SHIFT discards the operation.
        start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_diff", diff, 8'h00);
        chk("mid_bout", bout, 1'b0);
        gap = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) gap++;
        end
        chk("mid_quiet", gap, 0);
        do_op("post", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

        // Exhaustive WIDTH=2 sweep.
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    start2 = 1'b1; a2 = 2'(ai); b2 = 2'(bi); bin2 = 1'(ci);
                    @(posedge clk);
                    @(negedge clk); start2 = 1'b0;
                    lat = 1;
                    while (!done2 && lat < 10) begin @(negedge clk); lat++; end
                    mdl = {1'b0, a2} - {1'b0, b2} - {2'b00, bin2};
                    if (lat != 3) chk("w2_lat", lat, 3);
                    chk($sformatf("w2_%0d_%0d_%0d", ai, bi, ci), {bout2, diff2}, mdl);
                    @(negedge clk);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
